axi_mem_slave: RTL and testbench

AXI responder that terminates an `axi_if` master port in an on-chip word-addressed memory. It accepts write and read bursts on AW/W and AR, stores and returns data, and issues B and R responses. It is the far end of the register slices and the standard bench/sim target behind `reg_axi` chains. Write and read channels run independently and concurrently.

---
 rtl/axi_mem_slave_if.sv | 64 ++++++
 rtl/axi_mem_slave.sv | 217 +++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_slave_if.sv
// AXI bus bundle shared by masters, register slices and the memory responder.
// Carries only the channel signals the INCR word-memory path needs.
interface axi_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1
);
   localparam int STROBE_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic                    awvalid;
   logic                    awready;

   logic [DATA_WIDTH-1:0]   wdata;
   logic [STROBE_WIDTH-1:0] wstrb;
   logic                    wlast;
   logic [USER_WIDTH-1:0]   wuser;
   logic                    wvalid;
   logic                    wready;

   logic [1:0]              bresp;
   logic [USER_WIDTH-1:0]   buser;
   logic                    bvalid;
   logic                    bready;

   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic                    arvalid;
   logic                    arready;

   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic [USER_WIDTH-1:0]   ruser;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awlen, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wuser, wvalid,
      input  wready,
      input  bresp, buser, bvalid,
      output bready,
      output araddr, arlen, arvalid,
      input  arready,
      input  rdata, rresp, rlast, ruser, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awlen, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wuser, wvalid,
      output wready,
      output bresp, buser, bvalid,
      input  bready,
      input  araddr, arlen, arvalid,
      output arready,
      output rdata, rresp, rlast, ruser, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI responder terminating a master port in a word-addressed on-chip memory.
// Independent write (AW/W/B) and read (AR/R) FSMs share only the array.
module axi_mem_slave #(
   parameter int MEM_WORDS = 1024
) (
   input logic  clk,
   input logic  rst,
   axi_if.slave s_axi
);
   localparam int AW  = $bits(s_axi.awaddr);
   localparam int DW  = $bits(s_axi.wdata);
   localparam int SW  = DW / 8;
   localparam int SB  = $clog2(SW);
   localparam int IW  = AW + 1;
   localparam int MIW = $clog2(MEM_WORDS);

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

   logic [DW-1:0] mem_q [MEM_WORDS];

   wstate_e       wstate_q;
   logic          awready_q;
   logic          wready_q;
   logic          bvalid_q;
   logic [1:0]    bresp_q;
   logic [IW-1:0] widx_q;
   logic [7:0]    wlen_q;
   logic [7:0]    wcnt_q;
   logic          wdec_q;
   logic          wslv_q;

   rstate_e       rstate_q;
   logic          arready_q;
   logic          rvalid_q;
   logic          rlast_q;
   logic [DW-1:0] rdata_q;
   logic [1:0]    rresp_q;
   logic [IW-1:0] ridx_q;
   logic [7:0]    rlen_q;
   logic [7:0]    rcnt_q;

   logic          aw_hs;
   logic          w_hs;
   logic          ar_hs;
   logic          w_last_beat;
   logic          w_oor;
   logic          w_lerr;
   logic          w_we;
   logic [1:0]    bresp_d;
   logic [IW-1:0] aw_idx;
   logic [IW-1:0] ar_idx;
   logic [IW-1:0] r_idx_d;
   logic          r_oor;
   logic [DW-1:0] r_word_d;
   logic          unused_wuser;

   assign aw_hs  = s_axi.awvalid && awready_q;
   assign w_hs   = s_axi.wvalid && wready_q && (wstate_q == W_DATA);
   assign ar_hs  = s_axi.arvalid && arready_q;
   assign aw_idx = {1'b0, s_axi.awaddr >> SB};
   assign ar_idx = {1'b0, s_axi.araddr >> SB};

   assign w_last_beat = (wcnt_q == wlen_q);
   assign w_oor       = (widx_q >= IW'(MEM_WORDS));
   assign w_we        = w_hs && !w_oor;

   assign unused_wuser = ^s_axi.wuser;

   // Errors from earlier beats and the current one fold into the final response.
   always_comb begin
      w_lerr  = (s_axi.wlast != w_last_beat);
      bresp_d = OKAY;
      if (wdec_q || w_oor) begin
         bresp_d = DECERR;
      end else if (wslv_q || w_lerr) begin
         bresp_d = SLVERR;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < SW; b++) begin
            if (s_axi.wstrb[b]) begin
               mem_q[widx_q[MIW-1:0]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         widx_q    <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
         wdec_q    <= 1'b0;
         wslv_q    <= 1'b0;
      end else begin
         unique case (wstate_q)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (aw_hs) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  widx_q    <= aw_idx;
                  wlen_q    <= s_axi.awlen;
                  wcnt_q    <= '0;
                  wdec_q    <= 1'b0;
                  wslv_q    <= 1'b0;
                  wstate_q  <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  widx_q <= widx_q + IW'(1);
                  wcnt_q <= wcnt_q + 8'd1;
                  if (w_oor) wdec_q <= 1'b1;
                  if (w_lerr) wslv_q <= 1'b1;
                  if (w_last_beat) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= bresp_d;
                     wstate_q <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_axi.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wstate_q  <= W_IDLE;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   // Array read is sampled at the same edge as any write: old data wins.
   always_comb begin
      r_idx_d  = (rstate_q == R_IDLE) ? ar_idx : ridx_q;
      r_oor    = (r_idx_d >= IW'(MEM_WORDS));
      r_word_d = '0;
      if (!r_oor) begin
         r_word_d = mem_q[r_idx_d[MIW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= OKAY;
         ridx_q    <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
      end else begin
         unique case (rstate_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (ar_hs) begin
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rdata_q   <= r_word_d;
                  rresp_q   <= r_oor ? DECERR : OKAY;
                  rlast_q   <= (s_axi.arlen == 8'd0);
                  ridx_q    <= r_idx_d + IW'(1);
                  rlen_q    <= s_axi.arlen;
                  rcnt_q    <= '0;
                  rstate_q  <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi.rready) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     rstate_q  <= R_IDLE;
                  end else begin
                     rdata_q <= r_word_d;
                     rresp_q <= r_oor ? DECERR : OKAY;
                     rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                     rcnt_q  <= rcnt_q + 8'd1;
                     ridx_q  <= ridx_q + IW'(1);
                  end
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.buser   = '0;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rlast   = rlast_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.ruser   = '0;
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: bursts, strobes, backpressure, errors, reset.
module tb_axi_mem_slave;
   logic clk;
   logic rst_n;
   int   n_run;
   int   n_fail;

   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] rd [16];
   logic [1:0]  rr [16];
   logic        rl [16];
   logic [1:0]  resp;
   int          n;

   axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(1)) bus ();

   axi_mem_slave #(.MEM_WORDS(16)) dut (
      .clk  (clk),
      .rst  (rst_n),
      .s_axi(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_w(input int i, input logic [31:0] d, input logic [3:0] s);
      wd[i] = d;
      ws[i] = s;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                           input bit badlast, input bit stall,
                           output logic [1:0] bresp);
      int k;
      bus.awaddr  = addr;
      bus.awlen   = len;
      bus.awvalid = 1'b1;
      k = 0;
      while (!bus.awready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("aw_wait", 64'(k < 50), 64'd1);
      @(negedge clk);
      bus.awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         if (stall && i == 3) begin
            bus.wvalid = 1'b0;
            repeat (2) begin
               @(negedge clk);
               check("b_early", 64'(bus.bvalid), 64'd0);
            end
         end
         bus.wvalid = 1'b1;
         bus.wdata  = wd[i];
         bus.wstrb  = ws[i];
         bus.wlast  = badlast ? (i == 0) : (i == int'(len));
         k = 0;
         while (!bus.wready && k < 50) begin
            @(negedge clk);
            k++;
         end
         if (k >= 50) check("w_wait", 64'(k), 64'd0);
         @(negedge clk);
      end
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      check("b_valid", {62'd0, bus.bvalid, bus.wready}, 64'b10);
      bus.bready = 1'b1;
      bresp = bus.bresp;
      @(negedge clk);
      bus.bready = 1'b0;
      check("aw_back", 64'(bus.awready), 64'd1);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                          input bit tog);
      int k;
      int got;
      int p;
      bit stalled;
      logic [34:0] held;
      bus.araddr  = addr;
      bus.arlen   = len;
      bus.arvalid = 1'b1;
      k = 0;
      while (!bus.arready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("ar_wait", 64'(k < 50), 64'd1);
      @(negedge clk);
      bus.arvalid = 1'b0;
      check("r_lat", {62'd0, bus.rvalid, bus.arready}, 64'b10);
      got = 0;
      p = 0;
      k = 0;
      stalled = 1'b0;
      held = '0;
      while (got <= int'(len) && k < 200) begin
         bus.rready = tog ? (p % 3 == 0) : 1'b1;
         p++;
         if (stalled) begin
            check("r_hold", {29'd0, bus.rlast, bus.rresp, bus.rdata}, {29'd0, held});
         end
         if (bus.rvalid && bus.rready) begin
            rd[got] = bus.rdata;
            rr[got] = bus.rresp;
            rl[got] = bus.rlast;
            got++;
            stalled = 1'b0;
         end else if (bus.rvalid) begin
            stalled = 1'b1;
            held = {bus.rlast, bus.rresp, bus.rdata};
         end
         @(negedge clk);
         k++;
      end
      bus.rready = 1'b0;
      check("r_beats", 64'(got), 64'(int'(len) + 1));
      check("r_end", {62'd0, bus.rvalid, bus.arready}, 64'b01);
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
      bus.wuser = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_ctl", {58'd0, bus.awready, bus.wready, bus.bvalid,
            bus.arready, bus.rvalid, bus.rlast}, 64'd0);
      check("rst_dat", {28'd0, bus.bresp, bus.rresp, bus.rdata}, 64'd0);
      rst_n = 1'b1;
      check("rdy_pre", {62'd0, bus.awready, bus.arready}, 64'b00);
      @(negedge clk);
      check("rdy_post", {62'd0, bus.awready, bus.arready}, 64'b11);

      set_w(0, 32'hDEADBEEF, 4'hF);
      do_write(32'h10, 8'd0, 1'b0, 1'b0, resp);
      check("single_b", 64'(resp), 64'h0);
      do_read(32'h10, 8'd0, 1'b0);
      check("single_r", {29'd0, rl[0], rr[0], rd[0]}, {29'd0, 1'b1, 2'b00, 32'hDEADBEEF});

      set_w(0, 32'hFFFFFFFF, 4'hF);
      do_write(32'h08, 8'd0, 1'b0, 1'b0, resp);
      set_w(0, 32'h11111111, 4'hF);
      set_w(1, 32'h22222222, 4'hF);
      set_w(2, 32'h33333333, 4'h3);
      set_w(3, 32'h44444444, 4'hF);
      do_write(32'h00, 8'd3, 1'b0, 1'b0, resp);
      check("strb_b", 64'(resp), 64'h0);
      do_read(32'h00, 8'd3, 1'b0);
      check("strb_r0", {29'd0, rl[0], rr[0], rd[0]}, {29'd0, 1'b0, 2'b00, 32'h11111111});
      check("strb_r1", {29'd0, rl[1], rr[1], rd[1]}, {29'd0, 1'b0, 2'b00, 32'h22222222});
      check("strb_r2", {29'd0, rl[2], rr[2], rd[2]}, {29'd0, 1'b0, 2'b00, 32'hFFFF3333});
      check("strb_r3", {29'd0, rl[3], rr[3], rd[3]}, {29'd0, 1'b1, 2'b00, 32'h44444444});

      for (int i = 0; i < 8; i++) set_w(i, 32'hC0DE0000 + 32'(i), 4'hF);
      do_write(32'h20, 8'd7, 1'b0, 1'b1, resp);
      check("bp_b", 64'(resp), 64'h0);
      do_read(32'h20, 8'd7, 1'b1);
      for (int i = 0; i < 8; i++) begin
         check("bp_r", {29'd0, rl[i], rr[i], rd[i]},
               {29'd0, (i == 7), 2'b00, 32'hC0DE0000 + 32'(i)});
      end

      set_w(0, 32'hAAAA0005, 4'hF);
      set_w(1, 32'hAAAA0006, 4'hF);
      do_write(32'h14, 8'd1, 1'b1, 1'b0, resp);
      check("wlast_b", 64'(resp), 64'h2);
      do_read(32'h14, 8'd1, 1'b0);
      check("wlast_r0", 64'(rd[0]), 64'hAAAA0005);
      check("wlast_r1", 64'(rd[1]), 64'hAAAA0006);

      set_w(0, 32'h5555AAAA, 4'hF);
      set_w(1, 32'h12345678, 4'hF);
      do_write(32'h3C, 8'd1, 1'b0, 1'b0, resp);
      check("oor_b", 64'(resp), 64'h3);
      do_read(32'h3C, 8'd1, 1'b0);
      check("oor_r0", {29'd0, rl[0], rr[0], rd[0]}, {29'd0, 1'b0, 2'b00, 32'h5555AAAA});
      check("oor_r1", {29'd0, rl[1], rr[1], rd[1]}, {29'd0, 1'b1, 2'b11, 32'h0});
      do_write(32'h3C, 8'd1, 1'b1, 1'b0, resp);
      check("prio_b", 64'(resp), 64'h3);

      for (int i = 0; i < 4; i++) set_w(i, 32'h90000000 + 32'(i), 4'hF);
      fork
         begin
            do_write(32'h00, 8'd3, 1'b0, 1'b0, resp);
         end
         begin
            do_read(32'h00, 8'd3, 1'b0);
         end
      join
      check("cc_b", 64'(resp), 64'h0);
      check("cc_r0", 64'(rd[0]), 64'h11111111);
      check("cc_r1", 64'(rd[1]), 64'h22222222);
      check("cc_r2", 64'(rd[2]), 64'hFFFF3333);
      check("cc_r3", 64'(rd[3]), 64'h44444444);
      do_read(32'h00, 8'd3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("cc_new", 64'(rd[i]), 64'(32'h90000000 + 32'(i)));
      end

      bus.awaddr  = 32'h20;
      bus.awlen   = 8'd3;
      bus.awvalid = 1'b1;
      n = 0;
      while (!bus.awready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rs_aw", 64'(n < 50), 64'd1);
      @(negedge clk);
      bus.awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.wvalid = 1'b1;
         bus.wdata  = 32'h77770000 + 32'(i);
         bus.wstrb  = 4'hF;
         bus.wlast  = 1'b0;
         check("rs_wrdy", 64'(bus.wready), 64'd1);
         @(negedge clk);
      end
      bus.wdata = 32'h77770002;
      #2 rst_n = 1'b0;
      #1;
      check("rs_async", {58'd0, bus.awready, bus.wready, bus.bvalid,
            bus.arready, bus.rvalid, bus.rlast}, 64'd0);
      bus.wvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rs_rel", 64'(bus.awready), 64'd0);
      @(negedge clk);
      check("rs_aw1", 64'(bus.awready), 64'd1);
      do_read(32'h20, 8'd3, 1'b0);
      check("rs_m0", 64'(rd[0]), 64'h77770000);
      check("rs_m1", 64'(rd[1]), 64'h77770001);
      check("rs_m2", 64'(rd[2]), 64'hC0DE0002);
      check("rs_m3", 64'(rd[3]), 64'hC0DE0003);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
